// File: rtl/btb_reader.sv
// btb_reader: direct-mapped branch target buffer with 2-bit saturating
// direction counters and a one-cycle registered lookup path.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset
//   stall          hold prediction outputs, ignore lookup_valid
//   lookup_valid   fetch-side lookup request
//   lookup_pc      fetch PC to predict
//   update_valid   resolved-branch write request
//   update_pc      PC of the resolved branch
//   update_taken   resolved direction
//   update_target  resolved branch target
//   pred_valid     prediction outputs valid
//   pred_hit       tag match on a valid entry
//   pred_taken     predict taken
//   pred_target    next fetch PC
//
// Address split: index = pc[IDX:1], tag = pc[15:IDX+1], pc[0] ignored.
//
// Configuration macro BTB_BYPASS_EN: when defined, an update to the same
// index as a same-cycle lookup is forwarded so the lookup sees post-update
// contents. When undefined, the lookup reads the pre-update contents.
//
// Handshake: lookup_valid and update_valid are single-cycle qualifiers with
// no back-pressure; a request is consumed at the rising edge where it is
// high (lookup additionally requires stall=0, update is never blocked).
module btb_reader #(
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        lookup_valid,
  input  logic [15:0] lookup_pc,
  input  logic        update_valid,
  input  logic [15:0] update_pc,
  input  logic        update_taken,
  input  logic [15:0] update_target,
  output logic        pred_valid,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [15:0] pred_target
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 15 - IDX;

  logic            ent_valid  [ENTRIES];
  logic [TAGW-1:0] ent_tag    [ENTRIES];
  logic [15:0]     ent_target [ENTRIES];
  logic [1:0]      ent_ctr    [ENTRIES];

  logic [IDX-1:0]  l_idx;
  logic [TAGW-1:0] l_tag;
  logic [IDX-1:0]  u_idx;
  logic [TAGW-1:0] u_tag;

  assign l_idx = lookup_pc[IDX:1];
  assign l_tag = lookup_pc[15:IDX+1];
  assign u_idx = update_pc[IDX:1];
  assign u_tag = update_pc[15:IDX+1];

  // Bit 0 of both PCs is architecturally ignored (word-aligned fetch).
  logic unused_pc_lsb;
  assign unused_pc_lsb = lookup_pc[0] ^ update_pc[0];

  // New contents of the entry addressed by the update.
  logic        u_hit;
  logic [1:0]  u_ctr_new;
  logic [15:0] u_target_new;

  always_comb begin
    u_hit        = ent_valid[u_idx] && (ent_tag[u_idx] == u_tag);
    u_ctr_new    = update_taken ? 2'b10 : 2'b01;
    u_target_new = update_target;
    if (u_hit) begin
      if (update_taken) begin
        u_ctr_new = (ent_ctr[u_idx] == 2'b11) ? 2'b11 : ent_ctr[u_idx] + 2'b01;
      end else begin
        u_ctr_new    = (ent_ctr[u_idx] == 2'b00) ? 2'b00 : ent_ctr[u_idx] - 2'b01;
        u_target_new = ent_target[u_idx];
      end
    end
  end

  // Entry seen by the lookup, optionally with same-cycle update forwarded.
  logic            r_valid;
  logic [TAGW-1:0] r_tag;
  logic [15:0]     r_target;
  logic [1:0]      r_ctr;
  logic            nxt_hit;
  logic            nxt_taken;
  logic [15:0]     nxt_target;

  always_comb begin
    r_valid  = ent_valid[l_idx];
    r_tag    = ent_tag[l_idx];
    r_target = ent_target[l_idx];
    r_ctr    = ent_ctr[l_idx];
`ifdef BTB_BYPASS_EN
    if (update_valid && (u_idx == l_idx)) begin
      r_valid  = 1'b1;
      r_tag    = u_tag;
      r_target = u_target_new;
      r_ctr    = u_ctr_new;
    end
`endif
    nxt_hit    = lookup_valid && r_valid && (r_tag == l_tag);
    nxt_taken  = nxt_hit && r_ctr[1];
    nxt_target = nxt_taken ? r_target : lookup_pc + 16'd2;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_valid[i]  <= 1'b0;
        ent_tag[i]    <= '0;
        ent_target[i] <= 16'hFFFF;
        ent_ctr[i]    <= 2'b01;
      end
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= 16'hFFFF;
    end else begin
      // Updates proceed regardless of stall.
      if (update_valid) begin
        ent_valid[u_idx]  <= 1'b1;
        ent_tag[u_idx]    <= u_tag;
        ent_target[u_idx] <= u_target_new;
        ent_ctr[u_idx]    <= u_ctr_new;
      end
      if (!stall) begin
        pred_valid  <= lookup_valid;
        pred_hit    <= nxt_hit;
        pred_taken  <= nxt_taken;
        pred_target <= nxt_target;
      end
    end
  end

endmodule
